commit_unit: RTL and testbench
==============================

COMMIT_UNIT -- requirements
Module: commit_unit

Interface
REQ-001 The module SHALL have parameter XCPT_HANDLER_PC, default 32'h0000_2000, meaning the redirect target on an exception.
REQ-002 The module SHALL have parameter FLUSH_CYCLES, default 2, range 1-15, meaning the cycles invalidate_buffer is held.
REQ-003 clock  in  1  the single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low.
REQ-005 commit_valid  in  1  the ROB presents a retiring entry this cycle.
REQ-006 commit_rf_we, commit_rf_dest[4:0], commit_rf_data[31:0]  in  register writeback request.
REQ-007 commit_instr_id  in  2  ROB slot id of the retiring entry.
REQ-008 commit_xcpt_valid, commit_xcpt_type[2:0], commit_xcpt_pc[31:0], commit_xcpt_addr[31:0]  in  exception report.
REQ-009 commit_tlb_entry, commit_tlb_id, commit_tlb_info[52:0]  in  TLB fill request.
REQ-010 rf_write_en, rf_write_dest[4:0], rf_write_data[31:0]  out  registered register-file write port.
REQ-011 itlb_we, dtlb_we, tlb_write_info[52:0]  out  registered TLB write ports.
REQ-012 invalidate_buffer  out  1  ROB flush.
REQ-013 flush_pipeline  out  1  front-end and execution-stage kill.
REQ-014 pc_redirect_valid, pc_redirect[31:0]  out  fetch redirect.
REQ-015 xcpt_cause[2:0], xcpt_epc[31:0], xcpt_badaddr[31:0]  out  last-exception status registers.
REQ-016 xcpt_count  out  16  saturating exception counter.
REQ-017 busy  out  1  high whenever the state is not RUN.

Function
REQ-018 The FSM SHALL have three states: RUN, FLUSH and REDIRECT.
REQ-019 A commit is accepted only when the FSM is in RUN and commit_valid=1; all other commit inputs are ignored.
REQ-020 For an accepted commit with commit_xcpt_valid=0:
- rf_write_en = commit_rf_we, with dest and data, one cycle later.
- itlb_we = commit_tlb_entry & !commit_tlb_id, one cycle later.
- dtlb_we = commit_tlb_entry & commit_tlb_id, one cycle later.
REQ-021 For an accepted commit with commit_xcpt_valid=1:
- rf_write_en, itlb_we and dtlb_we stay 0.
- xcpt_cause, xcpt_epc and xcpt_badaddr capture the inputs.
- xcpt_count increments, saturating at 16'hFFFF.
- The FSM moves to FLUSH.
REQ-022 In FLUSH, invalidate_buffer and flush_pipeline SHALL be 1 for exactly FLUSH_CYCLES consecutive cycles, starting the cycle after the exception commit; the FSM then moves to REDIRECT.
REQ-023 In REDIRECT, pc_redirect_valid=1 and pc_redirect=XCPT_HANDLER_PC for exactly one cycle; the FSM then returns to RUN.
REQ-024 A second exception is impossible while busy=1, because commits are ignored outside RUN.
REQ-025 An internal 2-bit expected-id counter SHALL increment, with wrap 3->0, on every accepted commit, and SHALL clear to 0 on the last FLUSH cycle.
REQ-026 All outputs SHALL be registered.
REQ-027 Commit-to-output latency SHALL be exactly 1 cycle.

Reset
REQ-028 Asserting reset SHALL immediately force:
- FSM to RUN and the expected-id counter to 0.
- All write enables, invalidate_buffer, flush_pipeline, pc_redirect_valid and busy to 0.
- xcpt_cause, xcpt_epc, xcpt_badaddr, xcpt_count, pc_redirect, rf_write_dest, rf_write_data and tlb_write_info to 0.
REQ-029 Reset asserted in FLUSH or REDIRECT SHALL abort the sequence, with no later redirect.

Configuration
REQ-030 With macro COMMIT_ORDER_CHECK_EN defined:
- Output commit_order_error (1 bit) SHALL exist.
- It is a sticky flag, cleared only by reset.
- It is set one cycle after an accepted commit whose commit_instr_id differs from the expected-id counter.
REQ-031 Without COMMIT_ORDER_CHECK_EN, the port and the check logic SHALL be absent; the expected-id counter remains.

Structure
REQ-032 Shared package contents:
- the FSM state enum;
- the exception-type encoding (3-bit);
- the TLB-info width (53);
- the ROB-id width (2).
REQ-033 Sub-module flush_timer SHALL implement the 4-bit FLUSH_CYCLES down-counter with start and done signals; all other logic is flat.

Verification
REQ-034 Ordinary commit: commit id 0, rf_we=1, dest 5, data 32'hDEADBEEF -> next cycle rf_write_en=1, dest 5, data DEADBEEF; no flush.
REQ-035 TLB fill: commit_tlb_entry=1, id=1, info=53'h1234 -> next cycle dtlb_we=1, itlb_we=0, tlb_write_info=53'h1234.
REQ-036 Exception: xcpt_valid=1, type 3'd2, pc 32'h100, addr 32'h40, with rf_we=1 ->
- no RF write;
- epc 100, badaddr 40, cause 2, count 1;
- invalidate_buffer high for 2 cycles;
- then pc_redirect_valid with 32'h2000 for 1 cycle.
REQ-037 Commit presented during FLUSH (commit_valid=1, rf_we=1) -> no rf_write_en; after redirect, a commit with id 0 is accepted and commit_order_error stays 0.
REQ-038 With COMMIT_ORDER_CHECK_EN: commit ids 0, 1, 3 -> commit_order_error rises one cycle after the id-3 commit and persists.
REQ-039 Reset asserted on the first FLUSH cycle -> invalidate_buffer drops immediately, busy=0, and no pc_redirect_valid ever follows.

Source files
------------

// File: rtl/commit_unit_pkg.sv
// rtl/commit_unit_pkg.sv - shared types and widths for the commit unit
package commit_unit_pkg;

  localparam int TLB_INFO_W  = 53;
  localparam int ROB_ID_W    = 2;
  localparam int FLUSH_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    XCPT_NONE          = 3'd0,
    XCPT_ILLEGAL_INSTR = 3'd1,
    XCPT_LOAD_FAULT    = 3'd2,
    XCPT_STORE_FAULT   = 3'd3,
    XCPT_FETCH_FAULT   = 3'd4,
    XCPT_ECALL         = 3'd5,
    XCPT_BREAKPOINT    = 3'd6,
    XCPT_MISALIGNED    = 3'd7
  } xcpt_type_t;

  function automatic logic [ROB_ID_W-1:0] next_rob_id(input logic [ROB_ID_W-1:0] id);
    return id + ROB_ID_W'(1);
  endfunction

endpackage

// File: rtl/commit_unit_flush_timer.sv
// rtl/commit_unit_flush_timer.sv - flush-length down-counter; done is high while the count is zero
module flush_timer
  import commit_unit_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic done
);

  localparam logic [FLUSH_CNT_W-1:0] LOAD_VALUE = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  logic [FLUSH_CNT_W-1:0] count;

  // Loading N-1 makes the FLUSH state last exactly N cycles, since done is sampled each FLUSH cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (start) begin
      count <= LOAD_VALUE;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/commit_unit.sv
// rtl/commit_unit.sv - ROB retirement: RF/TLB writeback, exception capture, flush and redirect
// Optional feature macro: COMMIT_ORDER_CHECK_EN (adds sticky commit_order_error output)
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter logic [31:0] XCPT_HANDLER_PC = 32'h0000_2000,
  parameter int unsigned FLUSH_CYCLES    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  commit_valid,
  input  logic                  commit_rf_we,
  input  logic [4:0]            commit_rf_dest,
  input  logic [31:0]           commit_rf_data,
  input  logic [ROB_ID_W-1:0]   commit_instr_id,
  input  logic                  commit_xcpt_valid,
  input  logic [2:0]            commit_xcpt_type,
  input  logic [31:0]           commit_xcpt_pc,
  input  logic [31:0]           commit_xcpt_addr,
  input  logic                  commit_tlb_entry,
  input  logic                  commit_tlb_id,
  input  logic [TLB_INFO_W-1:0] commit_tlb_info,
  output logic                  rf_write_en,
  output logic [4:0]            rf_write_dest,
  output logic [31:0]           rf_write_data,
  output logic                  itlb_we,
  output logic                  dtlb_we,
  output logic [TLB_INFO_W-1:0] tlb_write_info,
  output logic                  invalidate_buffer,
  output logic                  flush_pipeline,
  output logic                  pc_redirect_valid,
  output logic [31:0]           pc_redirect,
  output logic [2:0]            xcpt_cause,
  output logic [31:0]           xcpt_epc,
  output logic [31:0]           xcpt_badaddr,
  output logic [15:0]           xcpt_count,
`ifdef COMMIT_ORDER_CHECK_EN
  output logic                  commit_order_error,
`endif
  output logic                  busy
);

  state_t              state;
  state_t              state_next;
  logic                accept;
  logic                take_xcpt;
  logic                retire;
  logic                flush_done;
  logic                flush_last;
  logic [ROB_ID_W-1:0] expected_id;

  assign accept     = (state == ST_RUN) && commit_valid;
  assign take_xcpt  = accept && commit_xcpt_valid;
  assign retire     = accept && !commit_xcpt_valid;
  assign flush_last = (state == ST_FLUSH) && flush_done;

  flush_timer #(
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) u_flush_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .start(take_xcpt),
    .done (flush_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:      if (take_xcpt) state_next = ST_FLUSH;
      ST_FLUSH:    if (flush_done) state_next = ST_REDIRECT;
      ST_REDIRECT: state_next = ST_RUN;
      default:     state_next = ST_RUN;
    endcase
  end

  // Status outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      invalidate_buffer <= 1'b0;
      flush_pipeline    <= 1'b0;
      pc_redirect_valid <= 1'b0;
      pc_redirect       <= '0;
      busy              <= 1'b0;
    end else begin
      invalidate_buffer <= (state_next == ST_FLUSH);
      flush_pipeline    <= (state_next == ST_FLUSH);
      pc_redirect_valid <= (state_next == ST_REDIRECT);
      busy              <= (state_next != ST_RUN);
      if (state_next == ST_REDIRECT) begin
        pc_redirect <= XCPT_HANDLER_PC;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_write_en    <= 1'b0;
      rf_write_dest  <= '0;
      rf_write_data  <= '0;
      itlb_we        <= 1'b0;
      dtlb_we        <= 1'b0;
      tlb_write_info <= '0;
    end else begin
      rf_write_en <= retire && commit_rf_we;
      itlb_we     <= retire && commit_tlb_entry && !commit_tlb_id;
      dtlb_we     <= retire && commit_tlb_entry && commit_tlb_id;
      if (retire && commit_rf_we) begin
        rf_write_dest <= commit_rf_dest;
        rf_write_data <= commit_rf_data;
      end
      if (retire && commit_tlb_entry) begin
        tlb_write_info <= commit_tlb_info;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xcpt_cause   <= '0;
      xcpt_epc     <= '0;
      xcpt_badaddr <= '0;
      xcpt_count   <= '0;
    end else if (take_xcpt) begin
      xcpt_cause   <= commit_xcpt_type;
      xcpt_epc     <= commit_xcpt_pc;
      xcpt_badaddr <= commit_xcpt_addr;
      if (xcpt_count != 16'hFFFF) begin
        xcpt_count <= xcpt_count + 16'd1;
      end
    end
  end

  // The ROB restarts numbering at slot 0 after a flush, so the expectation follows it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expected_id <= '0;
    end else if (flush_last) begin
      expected_id <= '0;
    end else if (accept) begin
      expected_id <= next_rob_id(expected_id);
    end
  end

`ifdef COMMIT_ORDER_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_order_error <= 1'b0;
    end else if (accept && (commit_instr_id != expected_id)) begin
      commit_order_error <= 1'b1;
    end
  end
`else
  logic unused_order_inputs;
  assign unused_order_inputs = ^{commit_instr_id, expected_id};
`endif

endmodule

// File: tb/tb_commit_unit.sv
// tb/tb_commit_unit.sv - randomized self-checking bench for commit_unit against a cycle-level reference model
module tb_commit_unit;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        commit_valid, commit_rf_we, commit_xcpt_valid, commit_tlb_entry, commit_tlb_id;
  logic [4:0]  commit_rf_dest;
  logic [31:0] commit_rf_data, commit_xcpt_pc, commit_xcpt_addr;
  logic [1:0]  commit_instr_id;
  logic [2:0]  commit_xcpt_type;
  logic [52:0] commit_tlb_info;
  logic        rf_write_en, itlb_we, dtlb_we, invalidate_buffer, flush_pipeline, pc_redirect_valid, busy;
  logic [4:0]  rf_write_dest;
  logic [31:0] rf_write_data, pc_redirect, xcpt_epc, xcpt_badaddr;
  logic [52:0] tlb_write_info;
  logic [2:0]  xcpt_cause;
  logic [15:0] xcpt_count;
`ifdef COMMIT_ORDER_CHECK_EN
  logic        commit_order_error;
`endif

  int total = 0;
  int bad = 0;

  // reference model state
  int          m_blocked;
  logic [1:0]  m_exp;
  logic        m_err, m_rf_en, m_itlb, m_dtlb;
  logic [4:0]  m_dest;
  logic [31:0] m_data, m_epc, m_bad, m_pc;
  logic [52:0] m_info;
  logic [2:0]  m_cause;
  int          m_count;

  commit_unit dut (
    .clk(clk), .rst_n(rst_n),
    .commit_valid(commit_valid), .commit_rf_we(commit_rf_we), .commit_rf_dest(commit_rf_dest),
    .commit_rf_data(commit_rf_data), .commit_instr_id(commit_instr_id),
    .commit_xcpt_valid(commit_xcpt_valid), .commit_xcpt_type(commit_xcpt_type),
    .commit_xcpt_pc(commit_xcpt_pc), .commit_xcpt_addr(commit_xcpt_addr),
    .commit_tlb_entry(commit_tlb_entry), .commit_tlb_id(commit_tlb_id), .commit_tlb_info(commit_tlb_info),
    .rf_write_en(rf_write_en), .rf_write_dest(rf_write_dest), .rf_write_data(rf_write_data),
    .itlb_we(itlb_we), .dtlb_we(dtlb_we), .tlb_write_info(tlb_write_info),
    .invalidate_buffer(invalidate_buffer), .flush_pipeline(flush_pipeline),
    .pc_redirect_valid(pc_redirect_valid), .pc_redirect(pc_redirect),
    .xcpt_cause(xcpt_cause), .xcpt_epc(xcpt_epc), .xcpt_badaddr(xcpt_badaddr), .xcpt_count(xcpt_count),
`ifdef COMMIT_ORDER_CHECK_EN
    .commit_order_error(commit_order_error),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_blocked = 0; m_exp = 2'd0; m_err = 1'b0;
    m_rf_en = 1'b0; m_itlb = 1'b0; m_dtlb = 1'b0;
    m_dest = '0; m_data = '0; m_info = '0;
    m_cause = '0; m_epc = '0; m_bad = '0; m_count = 0; m_pc = '0;
  endtask

  // Commits are refused for FC flush cycles plus one redirect cycle after an exception.
  task automatic model_step();
    bit acc;
    acc = (m_blocked == 0) && commit_valid;
    m_rf_en = 1'b0; m_itlb = 1'b0; m_dtlb = 1'b0;
    if (acc) begin
      if (commit_instr_id != m_exp) m_err = 1'b1;
      m_exp = m_exp + 2'd1;
      if (commit_xcpt_valid) begin
        m_cause = commit_xcpt_type; m_epc = commit_xcpt_pc; m_bad = commit_xcpt_addr;
        if (m_count < 65535) m_count++;
      end else begin
        m_rf_en = commit_rf_we;
        if (commit_rf_we) begin m_dest = commit_rf_dest; m_data = commit_rf_data; end
        m_itlb = commit_tlb_entry && !commit_tlb_id;
        m_dtlb = commit_tlb_entry && commit_tlb_id;
        if (commit_tlb_entry) m_info = commit_tlb_info;
      end
    end
    if (m_blocked == 2) m_exp = 2'd0;
    if (m_blocked > 0) m_blocked--;
    else if (acc && commit_xcpt_valid) m_blocked = FC + 1;
    if (m_blocked == 1) m_pc = 32'h0000_2000;
  endtask

  task automatic check_all();
    check("rf_write_en", rf_write_en, m_rf_en);
    if (m_rf_en) begin
      check("rf_write_dest", rf_write_dest, m_dest);
      check("rf_write_data", rf_write_data, m_data);
    end
    check("itlb_we", itlb_we, m_itlb);
    check("dtlb_we", dtlb_we, m_dtlb);
    if (m_itlb || m_dtlb) check("tlb_write_info", tlb_write_info, m_info);
    check("invalidate_buffer", invalidate_buffer, m_blocked > 1);
    check("flush_pipeline", flush_pipeline, m_blocked > 1);
    check("pc_redirect_valid", pc_redirect_valid, m_blocked == 1);
    check("pc_redirect", pc_redirect, m_pc);
    check("busy", busy, m_blocked > 0);
    check("xcpt_cause", xcpt_cause, m_cause);
    check("xcpt_epc", xcpt_epc, m_epc);
    check("xcpt_badaddr", xcpt_badaddr, m_bad);
    check("xcpt_count", xcpt_count, 64'(m_count));
`ifdef COMMIT_ORDER_CHECK_EN
    check("commit_order_error", commit_order_error, m_err);
`endif
  endtask

  task automatic drive(input bit v, input bit we, input logic [4:0] dest, input logic [31:0] data,
                       input logic [1:0] id, input bit xv, input logic [2:0] xt, input logic [31:0] xpc,
                       input logic [31:0] xaddr, input bit te, input bit ti, input logic [52:0] info);
    commit_valid = v; commit_rf_we = we; commit_rf_dest = dest; commit_rf_data = data;
    commit_instr_id = id; commit_xcpt_valid = xv; commit_xcpt_type = xt; commit_xcpt_pc = xpc;
    commit_xcpt_addr = xaddr; commit_tlb_entry = te; commit_tlb_id = ti; commit_tlb_info = info;
  endtask

  task automatic idle();
    drive(0, 0, '0, '0, '0, 0, '0, '0, '0, 0, 0, '0);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    model_reset();
    @(negedge clk);
    do_reset();

    // ordinary commit, TLB fill, then an exception carrying rf_we
    drive(1, 1, 5'd5, 32'hDEADBEEF, 2'd0, 0, '0, '0, '0, 0, 0, '0);
    step();
    check("ord_rf_en", rf_write_en, 1'b1);
    check("ord_rf_data", rf_write_data, 32'hDEADBEEF);
    check("ord_no_flush", invalidate_buffer, 1'b0);
    drive(1, 0, '0, '0, 2'd1, 0, '0, '0, '0, 1, 1, 53'h1234);
    step();
    check("tlb_dtlb", dtlb_we, 1'b1);
    check("tlb_itlb", itlb_we, 1'b0);
    check("tlb_info", tlb_write_info, 53'h1234);
    drive(1, 1, 5'd7, 32'h55, 2'd2, 1, 3'd2, 32'h100, 32'h40, 0, 0, '0);
    step();
    check("xc_no_rf", rf_write_en, 1'b0);
    check("xc_epc", xcpt_epc, 32'h100);
    check("xc_bad", xcpt_badaddr, 32'h40);
    check("xc_cause", xcpt_cause, 3'd2);
    check("xc_count", xcpt_count, 16'd1);
    check("xc_inval1", invalidate_buffer, 1'b1);
    drive(1, 1, 5'd9, 32'h99, 2'd3, 0, '0, '0, '0, 0, 0, '0);
    step();
    check("fl_no_rf", rf_write_en, 1'b0);
    check("xc_inval2", invalidate_buffer, 1'b1);
    step();
    check("redir_valid", pc_redirect_valid, 1'b1);
    check("redir_pc", pc_redirect, 32'h2000);
    check("redir_inval", invalidate_buffer, 1'b0);
    step();
    check("after_redir", pc_redirect_valid, 1'b0);
    check("after_busy", busy, 1'b0);
    drive(1, 1, 5'd3, 32'hA5A5, 2'd0, 0, '0, '0, '0, 0, 0, '0);
    step();
    check("resume_rf_en", rf_write_en, 1'b1);
    idle();
    step();

`ifdef COMMIT_ORDER_CHECK_EN
    do_reset();
    drive(1, 0, '0, '0, 2'd0, 0, '0, '0, '0, 0, 0, '0); step();
    check("ord_err_id0", commit_order_error, 1'b0);
    drive(1, 0, '0, '0, 2'd1, 0, '0, '0, '0, 0, 0, '0); step();
    drive(1, 0, '0, '0, 2'd3, 0, '0, '0, '0, 0, 0, '0); step();
    check("ord_err_rise", commit_order_error, 1'b1);
    idle(); step(); step();
    check("ord_err_sticky", commit_order_error, 1'b1);
`endif

    // reset on the first flush cycle aborts the sequence
    do_reset();
    drive(1, 0, '0, '0, 2'd0, 1, 3'd5, 32'h300, 32'h80, 0, 0, '0);
    step();
    check("rst_fl_inval", invalidate_buffer, 1'b1);
    idle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_inval_drop", invalidate_buffer, 1'b0);
    check("rst_busy_drop", busy, 1'b0);
    check("rst_count", xcpt_count, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step();

    for (int i = 0; i < 800; i++) begin
      logic [1:0] id;
      id = ($urandom_range(0, 19) == 0) ? 2'($urandom) : m_exp;
      drive($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom), $urandom, id,
            $urandom_range(0, 9) == 0, 3'($urandom), $urandom, $urandom,
            1'($urandom), 1'($urandom), {21'($urandom), 32'($urandom)});
      step();
    end
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
